// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative tag controller: derived field widths
// and the controller FSM state encoding.
package cache_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLookup = 2'd1,
    StUpdate = 2'd2
  } state_e;

  function automatic int unsigned offset_w(input int unsigned block_bytes);
    return $clog2(block_bytes);
  endfunction

  function automatic int unsigned sets_of(input int unsigned cache_bytes,
                                          input int unsigned block_bytes,
                                          input int unsigned ways);
    return cache_bytes / (block_bytes * ways);
  endfunction

  // Zero when the cache has a single set.
  function automatic int unsigned index_w(input int unsigned cache_bytes,
                                          input int unsigned block_bytes,
                                          input int unsigned ways);
    return $clog2(sets_of(cache_bytes, block_bytes, ways));
  endfunction

  function automatic int unsigned tag_w(input int unsigned cache_bytes,
                                        input int unsigned block_bytes,
                                        input int unsigned ways);
    return 32 - offset_w(block_bytes) - index_w(cache_bytes, block_bytes, ways);
  endfunction

  function automatic int unsigned way_w(input int unsigned ways);
    return $clog2(ways);
  endfunction

endpackage

// File: rtl/cache_lru_shift.sv
// Move-to-front reorder of one set: the line at position pos is dropped, ways
// 0..pos-1 slide down by one, and new_line lands at way 0 (MRU). A miss uses
// pos = WAYS-1 so the LRU line falls off the end.
module cache_lru_shift #(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned LINE_W = 32
) (
  input  logic [WAYS-1:0][LINE_W-1:0] set_in,
  input  logic [$clog2(WAYS)-1:0]     pos,
  input  logic [LINE_W-1:0]           new_line,
  output logic [WAYS-1:0][LINE_W-1:0] set_out
);

  // Ways above pos keep their place; ways up to pos take their upper neighbour.
  always_comb begin
    set_out    = set_in;
    set_out[0] = new_line;
    for (int i = 1; i < int'(WAYS); i++) begin
      if (i <= int'(pos)) set_out[i] = set_in[i-1];
    end
  end

endmodule

// File: rtl/assoc_cache_tagctl.sv
// Set-associative cache tag controller with true-LRU move-to-front ordering.
// One request at a time: IDLE -> LOOKUP -> UPDATE -> IDLE, response one cycle later.
// Optional hit/miss statistics counters are built when ASSOC_CACHE_STATS_EN is defined.
module assoc_cache_tagctl
  import cache_pkg::*;
#(
  parameter int unsigned WAYS        = 4,
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned CACHE_BYTES = 256,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_addr,
  input  logic                         req_write,
  output logic                         resp_valid,
  output logic                         resp_hit,
  output logic [way_w(WAYS)-1:0]       resp_way,
  output logic                         evict_valid,
  output logic                         evict_dirty,
  output logic [31:0]                  evict_addr,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);

  localparam int unsigned SETS   = sets_of(CACHE_BYTES, BLOCK_BYTES, WAYS);
  localparam int unsigned OFF_W  = offset_w(BLOCK_BYTES);
  localparam int unsigned IDX_W  = index_w(CACHE_BYTES, BLOCK_BYTES, WAYS);
  localparam int unsigned TAG_W  = tag_w(CACHE_BYTES, BLOCK_BYTES, WAYS);
  localparam int unsigned WAY_W  = way_w(WAYS);
  localparam int unsigned IDX_SW = (IDX_W == 0) ? 1 : IDX_W;
  // Line layout: {valid, dirty, tag}
  localparam int unsigned LINE_W = TAG_W + 2;

  state_e                         state_q;
  logic [31:0]                    addr_q;
  logic                           write_q;
  logic                           hit_q;
  logic [WAY_W-1:0]               way_q;
  logic [WAYS-1:0][LINE_W-1:0]    sets_q [SETS];

  logic [IDX_SW-1:0]              set_idx;
  logic [TAG_W-1:0]               req_tag;
  logic [WAYS-1:0][LINE_W-1:0]    cur_set;
  logic [WAYS-1:0][LINE_W-1:0]    new_set;
  logic                           lk_hit;
  logic [WAY_W-1:0]               lk_way;
  logic [WAY_W-1:0]               shift_pos;
  logic [LINE_W-1:0]              new_line;
  logic [LINE_W-1:0]              victim;
  logic                           victim_ev;
  logic [31:0]                    victim_addr;

  assign req_ready = (state_q == StIdle);
  assign set_idx   = (SETS == 1) ? '0 : IDX_SW'(addr_q >> OFF_W);
  assign req_tag   = TAG_W'(addr_q >> (OFF_W + IDX_W));
  assign cur_set   = sets_q[set_idx];

  // Parallel tag compare across all ways of the addressed set.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (cur_set[w][LINE_W-1] && (cur_set[w][TAG_W-1:0] == req_tag)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  // Build the line to promote and identify the victim for the update cycle.
  always_comb begin
    shift_pos   = hit_q ? way_q : WAY_W'(WAYS - 1);
    new_line    = {1'b1, (hit_q ? cur_set[way_q][LINE_W-2] : 1'b0) | write_q, req_tag};
    victim      = cur_set[WAYS-1];
    victim_ev   = !hit_q && victim[LINE_W-1];
    victim_addr = (32'(victim[TAG_W-1:0]) << (OFF_W + IDX_W)) | (32'(set_idx) << OFF_W);
  end

  cache_lru_shift #(
    .WAYS   (WAYS),
    .LINE_W (LINE_W)
  ) u_lru_shift (
    .set_in   (cur_set),
    .pos      (shift_pos),
    .new_line (new_line),
    .set_out  (new_set)
  );

  // Controller FSM; reset aborts any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (req_valid) state_q <= StLookup;
        StLookup: state_q <= StUpdate;
        StUpdate: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Request and lookup-result registers; no reset needed, qualified by state.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && req_valid) begin
      addr_q  <= req_addr;
      write_q <= req_write;
    end
    if (state_q == StLookup) begin
      hit_q <= lk_hit;
      way_q <= lk_way;
    end
  end

  // Tag array: cleared on reset, reordered set written back in UPDATE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < int'(SETS); s++) sets_q[s] <= '0;
    end else if (state_q == StUpdate) begin
      sets_q[set_idx] <= new_set;
    end
  end

  // Response registers: valid pulses once, payload holds until the next response.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_way    <= '0;
      evict_valid <= 1'b0;
      evict_dirty <= 1'b0;
      evict_addr  <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (state_q == StUpdate) begin
        resp_valid  <= 1'b1;
        resp_hit    <= hit_q;
        resp_way    <= hit_q ? way_q : '0;
        evict_valid <= victim_ev;
        evict_dirty <= victim_ev && victim[LINE_W-2];
        evict_addr  <= victim_ev ? victim_addr : 32'd0;
      end
    end
  end

`ifdef ASSOC_CACHE_STATS_EN
  // Saturating statistics, bumped alongside each response.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == StUpdate) begin
      if (hit_q && !(&hit_count))   hit_count  <= hit_count + 1'b1;
      if (!hit_q && !(&miss_count)) miss_count <= miss_count + 1'b1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_assoc_cache_tagctl.sv
// Self-checking bench for assoc_cache_tagctl at default parameters (4 ways,
// 16-byte lines, 4 sets). Directed table plus random traffic against an
// MRU-ordered queue model of each set.
module tb_assoc_cache_tagctl;

  localparam int unsigned WAYS = 4;
  localparam int unsigned SETS = 4;
  localparam int unsigned BLK  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        req_ready, resp_valid, resp_hit, evict_valid, evict_dirty;
  logic [1:0]  resp_way;
  logic [31:0] evict_addr;
  logic [15:0] hit_count, miss_count;

  always #5 clk = ~clk;

  assoc_cache_tagctl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_way    (resp_way),
    .evict_valid (evict_valid),
    .evict_dirty (evict_dirty),
    .evict_addr  (evict_addr),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

`ifdef ASSOC_CACHE_STATS_EN
  // Narrow-counter copy sharing the same stimulus, to observe saturation.
  logic        req_ready2, resp_valid2, resp_hit2, evict_valid2, evict_dirty2;
  logic [1:0]  resp_way2;
  logic [31:0] evict_addr2;
  logic [1:0]  hit_count2, miss_count2;

  assoc_cache_tagctl #(.CNT_W(2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready2),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .resp_valid  (resp_valid2),
    .resp_hit    (resp_hit2),
    .resp_way    (resp_way2),
    .evict_valid (evict_valid2),
    .evict_dirty (evict_dirty2),
    .evict_addr  (evict_addr2),
    .hit_count   (hit_count2),
    .miss_count  (miss_count2)
  );
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          hit;
    int unsigned way;
    bit          ev;
    bit          evd;
    logic [31:0] eva;
  } res_t;

  // Reference model: each set is a list of lines, most recently used first.
  typedef struct {
    int unsigned tag;
    bit          dirty;
  } mline_t;

  mline_t      mq [SETS][$];
  int unsigned m_hits, m_misses;

  task automatic model_reset();
    for (int s = 0; s < int'(SETS); s++) mq[s].delete();
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input logic [31:0] a, input bit w, output res_t r);
    int unsigned s, t;
    mline_t      ln;
    s = (a / BLK) % SETS;
    t = a / (BLK * SETS);
    r = '{hit: 1'b0, way: 0, ev: 1'b0, evd: 1'b0, eva: 32'd0};
    for (int i = 0; i < mq[s].size(); i++) begin
      if (mq[s][i].tag == t) begin
        r.hit = 1'b1;
        r.way = i;
      end
    end
    if (r.hit) begin
      ln       = mq[s][r.way];
      ln.dirty = ln.dirty | w;
      mq[s].delete(r.way);
      m_hits++;
    end else begin
      ln.tag   = t;
      ln.dirty = w;
      m_misses++;
    end
    mq[s].push_front(ln);
    if (mq[s].size() > WAYS) begin
      ln    = mq[s].pop_back();
      r.ev  = 1'b1;
      r.evd = ln.dirty;
      r.eva = ln.tag * (BLK * SETS) + s * BLK;
    end
  endtask

  function automatic int unsigned sat3(input int unsigned v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk_counters();
`ifdef ASSOC_CACHE_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
    chk("hit_count_sat", hit_count2, sat3(m_hits));
    chk("miss_count_sat", miss_count2, sat3(m_misses));
`else
    chk("hit_count_tied", hit_count, 0);
    chk("miss_count_tied", miss_count, 0);
`endif
  endtask

  // Two-cycle reset, released at a falling edge; checks the reset state.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_way", resp_way, 0);
    chk("rst_evict_valid", evict_valid, 0);
    chk("rst_evict_dirty", evict_dirty, 0);
    chk("rst_evict_addr", evict_addr, 0);
    chk_counters();
  endtask

  // Issue one request from a falling edge; optionally hammer req_valid while
  // busy (those must be ignored). Returns DUT response and model expectation.
  task automatic do_req(input logic [31:0] a, input bit w, input bit inject,
                        output res_t d, output res_t m);
    int lat;
    bit got;
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_write = 1'($urandom);
    model_access(a, w, m);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (inject) req_valid = (lat < 3);
      if (lat < 3) chk("ready_busy", req_ready, 0);
      got = resp_valid;
    end
    req_valid = 1'b0;
    chk("resp_latency", got ? lat : 99, 3);
    d = '{hit: resp_hit, way: resp_way, ev: evict_valid, evd: evict_dirty, eva: evict_addr};
    chk_counters();
    @(negedge clk);
    chk("resp_pulse", resp_valid, 0);
    chk("resp_hold", resp_hit, m.hit);
  endtask

  task automatic cmp(input string tag, input res_t d, input res_t e);
    chk({tag, "_hit"}, d.hit, e.hit);
    chk({tag, "_way"}, d.way, e.way);
    chk({tag, "_evict_valid"}, d.ev, e.ev);
    chk({tag, "_evict_dirty"}, d.evd, e.evd);
    if (e.ev) chk({tag, "_evict_addr"}, d.eva, e.eva);
  endtask

  typedef struct {
    bit          rst;
    logic [31:0] addr;
    bit          wr;
    res_t        exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input bit rst, input logic [31:0] addr, input bit wr,
                             input bit hit, input int unsigned way, input bit ev,
                             input bit evd, input logic [31:0] eva);
    vec_t x;
    x.rst  = rst;
    x.addr = addr;
    x.wr   = wr;
    x.exp  = '{hit: hit, way: way, ev: ev, evd: evd, eva: eva};
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t d, m;
    int   pulses;

    // Miss then hit at MRU.
    tbl.push_back(v(1, 32'h1000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h1000, 0, 1, 0, 0, 0, 0));
    // Fill set 0, fifth line evicts the oldest.
    tbl.push_back(v(1, 32'h000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h040, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h080, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h0C0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h100, 0, 0, 0, 1, 0, 32'h000));
    // Store hit at LRU promotes it; it later leaves dirty.
    tbl.push_back(v(1, 32'h000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h040, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h080, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h0C0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h000, 1, 1, 3, 0, 0, 0));
    tbl.push_back(v(0, 32'h100, 0, 0, 0, 1, 0, 32'h040));
    tbl.push_back(v(0, 32'h140, 0, 0, 0, 1, 0, 32'h080));
    tbl.push_back(v(0, 32'h180, 0, 0, 0, 1, 0, 32'h0C0));
    tbl.push_back(v(0, 32'h1C0, 0, 0, 0, 1, 1, 32'h000));
    // Move-to-front: way 3, then way 0, then a middle way.
    tbl.push_back(v(1, 32'h000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h040, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h080, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h0C0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h004, 0, 1, 3, 0, 0, 0));
    tbl.push_back(v(0, 32'h008, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h0C0, 0, 1, 1, 0, 0, 0));
    // Other sets stay independent.
    tbl.push_back(v(0, 32'h7FF0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 32'h7FFC, 0, 1, 0, 0, 0, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      do_req(tbl[i].addr, tbl[i].wr, (i % 3) == 1, d, m);
      cmp($sformatf("vec%0d", i), d, tbl[i].exp);
    end

    // Reset during LOOKUP aborts the request and clears the line.
    do_reset();
    do_req(32'h2000, 0, 0, d, m);
    cmp("abort_fill", d, m);
    req_valid = 1'b1;
    req_addr  = 32'h2000;
    req_write = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("abort_no_resp", pulses, 0);
    do_req(32'h2000, 0, 0, d, m);
    chk("abort_then_miss", d.hit, 0);
    cmp("abort_after", d, m);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) a = a | 32'hABC0_0000;
      if ($urandom_range(0, 63) == 0) do_reset();
      do_req(a, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, d, m);
      cmp("rand", d, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_cache_tagctl.md
ASSOC_CACHE_TAGCTL -- requirements
Module: assoc_cache_tagctl

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity (power of 2, 2..16).
REQ-002 SHALL have parameter BLOCK_BYTES, default 16, line size in bytes (power of 2).
REQ-003 SHALL have parameter CACHE_BYTES, default 256, total capacity; SETS = CACHE_BYTES/(BLOCK_BYTES*WAYS), power of 2, at least 1.
REQ-004 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  lookup request.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_addr  in  32  byte address; split as tag | index | offset.
REQ-010 req_write  in  1  request is a store; marks line dirty.
REQ-011 resp_valid  out  1  one-cycle response strobe.
REQ-012 resp_hit  out  1  hit (1) or miss (0).
REQ-013 resp_way  out  log2(WAYS)  way hit before reordering; 0 on miss.
REQ-014 evict_valid  out  1  miss displaced a valid line.
REQ-015 evict_dirty  out  1  displaced line was dirty.
REQ-016 evict_addr  out  32  {victim tag, index, zero offset}.
REQ-017 hit_count, miss_count  out  CNT_W each  statistics.

Function
REQ-018 Line state: valid, dirty, tag per way per set; way 0 = MRU, way WAYS-1 = LRU.
REQ-019 FSM: IDLE -> LOOKUP -> UPDATE -> IDLE; req_ready = 1 only in IDLE.
REQ-020 Accept on req_valid && req_ready; latch addr and write into registers.
REQ-021 LOOKUP: compare all ways of the set in parallel in one cycle; hit = valid && tag match.
REQ-022 UPDATE, hit at way k: ways 0..k-1 shift down one; line k moves to way 0 in one cycle; dirty |= req_write.
REQ-023 UPDATE, miss: ways shift down one; way 0 <= {valid 1, dirty req_write, tag}; old way WAYS-1 is the victim.
REQ-024 resp_valid SHALL pulse exactly one cycle, the cycle after UPDATE (acceptance edge + 3); resp_* and evict_* held until next response.
REQ-025 evict_valid = 0 on hit or when victim invalid; evict_dirty = 0 when evict_valid = 0.
REQ-026 Requests issued while req_ready = 0 SHALL be ignored; no queuing.
REQ-027 Back-to-back requests to the same set SHALL see prior update (no stale state).

Reset
REQ-028 reset SHALL clear all valid/dirty bits and counters and return FSM to IDLE within one cycle, including mid-operation; an in-flight request produces no response.
REQ-029 Reset values: req_ready 1 (after release), resp_valid 0, resp_hit 0, resp_way 0, evict_valid 0, evict_dirty 0, evict_addr 0, counters 0.

Configuration
REQ-030 Macro ASSOC_CACHE_STATS_EN defined: hit_count/miss_count increment on each response, saturating at all-ones.
REQ-031 Macro undefined: counters not built; hit_count and miss_count tied to 0.

Structure
REQ-032 Shared package cache_pkg SHALL hold the derived-width functions (offset, index, tag, way widths) and the FSM state enum.
REQ-033 One sub-module, cache_lru_shift, SHALL implement the per-set move-to-front reorder (inputs: set contents, position k, new line; output: reordered set).

Verification (defaults: 4 sets, offset [3:0], index [5:4])
REQ-034 After reset, read 0x0000_1000 -> miss, evict_valid 0; repeat -> hit, resp_way 0.
REQ-035 Reads 0x000, 0x040, 0x080, 0x0C0, then 0x100 -> 5th access misses, evict_valid 1, evict_addr 0x000, evict_dirty 0.
REQ-036 Fill as above, write 0x000 (hit, way 3), then read 0x100 -> evict_addr 0x040; later misses evict 0x000 with evict_dirty 1 on its eviction.
REQ-037 Hit at way 3 -> resp_way 3; immediate repeat -> resp_way 0 (move-to-front verified).
REQ-038 Assert reset during LOOKUP -> no resp_valid; next read of same address misses.
REQ-039 With ASSOC_CACHE_STATS_EN, 3 misses + 2 hits -> hit_count 2, miss_count 3; CNT_W 2 with 5 hits -> hit_count 3 (saturated).
